// File: rtl/seg_scan_ctrl_if.sv
// Load channel for seg_scan_ctrl: a display value offered over a valid/ready handshake.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load_valid;
    logic [4*NUM_DIGITS-1:0]   load_data;
    logic                      load_ready;

    modport master (output load_valid, output load_data, input load_ready);
    modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller sharing one external hex7seg decoder.
// Display updates are staged in a shadow register and committed only at frame boundaries.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    seg_scan_ctrl_if.slave        ld,
    input  logic                  blank_lz,
    output logic [3:0]            hex_out,
    input  logic [6:0]            seg_in,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_done
);
    localparam int DW      = 4 * NUM_DIGITS;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      DRIVE_END = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      GAP_END   = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [6:0]            SEG_OFF   = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = '1;
    localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);

    typedef enum logic {GAP, DRIVE} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [DW-1:0]           disp, disp_nxt;
    logic [DW-1:0]           shadow, shadow_nxt;
    logic                    pending, pending_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [6:0]              seg_nxt;
    logic                    frame_done_nxt;
    logic                    boundary;

    // A digit is dark when leading-zero blanking is on and it and every higher digit are zero.
    function automatic logic suppressed(input logic [IDX_W-1:0] i,
                                        input logic [DW-1:0]    d,
                                        input logic             blz);
        return blz && (i != '0) && ((d >> {i, 2'b00}) == '0);
    endfunction

    assign hex_out       = disp[{idx, 2'b00} +: 4];
    assign ld.load_ready = ~pending;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt + 1'b1;
        idx_nxt        = idx;
        disp_nxt       = disp;
        shadow_nxt     = shadow;
        pending_nxt    = pending;
        an_nxt         = an;
        seg_nxt        = seg;
        frame_done_nxt = 1'b0;
        boundary       = 1'b0;

        case (state)
            GAP: begin
                if (cnt == GAP_END) begin
                    state_nxt = DRIVE;
                    cnt_nxt   = '0;
                    if (!suppressed(idx, disp, blank_lz)) begin
                        an_nxt  = ~(AN_ONE << idx);
                        seg_nxt = seg_in;
                    end
                end
            end
            DRIVE: begin
                if (cnt == DRIVE_END) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                    an_nxt    = AN_OFF;
                    seg_nxt   = SEG_OFF;
                    if (idx == LAST_IDX) begin
                        idx_nxt  = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
        endcase

        // Only a value that was already pending commits here; a same-cycle transfer waits a frame.
        if (boundary) begin
            frame_done_nxt = 1'b1;
            if (pending) begin
                disp_nxt    = shadow;
                pending_nxt = 1'b0;
            end
        end

        if (ld.load_valid && !pending) begin
            shadow_nxt  = ld.load_data;
            pending_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= GAP;
            cnt        <= '0;
            idx        <= '0;
            disp       <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            disp       <= disp_nxt;
            shadow     <= shadow_nxt;
            pending    <= pending_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            frame_done <= frame_done_nxt;
        end
    end
endmodule
